// File: rtl/twiddle_cmul_sequencer.sv
// Complex twiddle multiply y = x*w sequenced over one shared external Q2.14 multiplier.
// Define CMUL_SAT_EN for saturating 16-bit results; the default build wraps and ties out_sat low.
module twiddle_cmul_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] x_re,
    input  logic [15:0] x_im,
    input  logic [15:0] w_re,
    input  logic [15:0] w_im,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    input  logic [15:0] mul_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] y_re,
    output logic [15:0] y_im,
    output logic        out_sat,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, OUT} state_e;

    state_e             state_q, state_d;
    logic        [15:0] x_re_q, x_re_d, x_im_q, x_im_d;
    logic        [15:0] w_re_q, w_re_d, w_im_q, w_im_d;
    logic signed [16:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
    logic        [15:0] y_re_q, y_re_d, y_im_q, y_im_d;
    logic               sat_q, sat_d;

    logic signed [16:0] p_ext;
    logic signed [16:0] sum_im;

    // A 17-bit sum leaves the 16-bit range exactly when its top two bits differ.
    function automatic logic ovf17(input logic signed [16:0] s);
        return s[16] ^ s[15];
    endfunction

    function automatic logic [15:0] to16(input logic signed [16:0] s);
`ifdef CMUL_SAT_EN
        if (ovf17(s)) return s[16] ? 16'h8000 : 16'h7FFF;
        return s[15:0];
`else
        return s[15:0];
`endif
    endfunction

    assign p_ext  = {mul_p[15], mul_p};
    assign sum_im = acc_im_q + p_ext;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        state_d  = state_q;
        x_re_d   = x_re_q;
        x_im_d   = x_im_q;
        w_re_d   = w_re_q;
        w_im_d   = w_im_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        y_re_d   = y_re_q;
        y_im_d   = y_im_q;
        sat_d    = sat_q;
        mul_a    = 16'h0000;
        mul_b    = 16'h0000;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_re_d   = x_re;
                    x_im_d   = x_im;
                    w_re_d   = w_re;
                    w_im_d   = w_im;
                    acc_re_d = '0;
                    acc_im_d = '0;
                    state_d  = M0;
                end
            end
            M0: begin
                mul_a    = x_re_q;
                mul_b    = w_re_q;
                acc_re_d = p_ext;
                state_d  = M1;
            end
            M1: begin
                mul_a    = x_im_q;
                mul_b    = w_im_q;
                acc_re_d = acc_re_q - p_ext;
                state_d  = M2;
            end
            M2: begin
                mul_a    = x_re_q;
                mul_b    = w_im_q;
                acc_im_d = p_ext;
                state_d  = M3;
            end
            M3: begin
                // The imaginary sum is completed and converted in the same cycle.
                mul_a    = x_im_q;
                mul_b    = w_re_q;
                acc_im_d = sum_im;
                y_re_d   = to16(acc_re_q);
                y_im_d   = to16(sum_im);
`ifdef CMUL_SAT_EN
                sat_d    = ovf17(acc_re_q) | ovf17(sum_im);
`else
                sat_d    = 1'b0;
`endif
                state_d  = OUT;
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            x_re_q   <= '0;
            x_im_q   <= '0;
            w_re_q   <= '0;
            w_im_q   <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            y_re_q   <= '0;
            y_im_q   <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_re_q   <= x_re_d;
            x_im_q   <= x_im_d;
            w_re_q   <= w_re_d;
            w_im_q   <= w_im_d;
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
            y_re_q   <= y_re_d;
            y_im_q   <= y_im_d;
            sat_q    <= sat_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == OUT);
    assign y_re      = y_re_q;
    assign y_im      = y_im_q;
    assign out_sat   = sat_q;

endmodule

// File: tb/tb_twiddle_cmul_sequencer.sv
// Self-checking bench for twiddle_cmul_sequencer: directed table, random vectors vs. a
// complex-arithmetic reference model, backpressure and mid-operation reset sequences.
module tb_twiddle_cmul_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x_re = '0, x_im = '0, w_re = '0, w_im = '0;
    logic [15:0] mul_a, mul_b, mul_p;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] y_re, y_im;
    logic        out_sat;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // External shared multiplier: bits [29:14] of the signed 32-bit product.
    logic signed [31:0] prod;
    assign prod  = $signed(mul_a) * $signed(mul_b);
    assign mul_p = prod[29:14];

    twiddle_cmul_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_re(x_re), .x_im(x_im), .w_re(w_re), .w_im(w_im),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .out_valid(out_valid), .out_ready(out_ready),
        .y_re(y_re), .y_im(y_im), .out_sat(out_sat), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: real-valued Q2.14 products floored to integers, then wrapped or clamped.
    function automatic int qmul(input logic [15:0] a, input logic [15:0] b);
        int p;
        p = (int'($signed(a)) * int'($signed(b))) >>> 14;
        p = p & 32'hFFFF;
        if (p >= 32768) p = p - 65536;
        return p;
    endfunction

    task automatic ref_cmul(input logic [15:0] xr, xi, wr, wi,
                            output logic [15:0] re, im, output logic sat);
        int sr, si;
        sr = qmul(xr, wr) - qmul(xi, wi);
        si = qmul(xr, wi) + qmul(xi, wr);
`ifdef CMUL_SAT_EN
        sat = (sr > 32767) || (sr < -32768) || (si > 32767) || (si < -32768);
        if (sr > 32767) sr = 32767; else if (sr < -32768) sr = -32768;
        if (si > 32767) si = 32767; else if (si < -32768) si = -32768;
`else
        sat = 1'b0;
`endif
        re = 16'(sr);
        im = 16'(si);
    endtask

    // Called at a negedge with the DUT idle. hold < 0: out_ready high in advance;
    // hold >= 0: out_ready low for 'hold' OUT cycles with in_valid pulsed meanwhile.
    task automatic run_txn(input string tag, input logic [15:0] xr, xi, wr, wi,
                           input logic [15:0] er, ei, input logic es, input int hold);
        logic [15:0] ea [4];
        logic [15:0] eb [4];
        ea = '{xr, xi, xr, xi};
        eb = '{wr, wi, wi, wr};
        out_ready = (hold < 0);
        check({tag, " in_ready idle"}, in_ready, 1);
        check({tag, " mul idle"}, {mul_a, mul_b}, 0);
        x_re = xr; x_im = xi; w_re = wr; w_im = wi;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x_re = 16'($urandom); x_im = 16'($urandom);
        w_re = 16'($urandom); w_im = 16'($urandom);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("%s mul_a M%0d", tag, c), mul_a, ea[c]);
            check($sformatf("%s mul_b M%0d", tag, c), mul_b, eb[c]);
            check($sformatf("%s out_valid low M%0d", tag, c), {busy, out_valid, in_ready}, 3'b100);
        end
        @(negedge clk);
        check({tag, " out_valid latency"}, out_valid, 1);
        check({tag, " y_re"}, y_re, er);
        check({tag, " y_im"}, y_im, ei);
        check({tag, " out_sat"}, out_sat, es);
        check({tag, " mul out"}, {mul_a, mul_b}, 0);
        if (hold >= 0) begin
            for (int h = 0; h < hold; h++) begin
                in_valid = 1'b1;
                @(negedge clk);
                in_valid = 1'b0;
                check({tag, " hold stable"}, {out_valid, in_ready, out_sat, y_re, y_im},
                      {1'b1, 1'b0, es, er, ei});
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        check({tag, " handshake done"}, {out_valid, in_ready, busy}, 3'b010);
        out_ready = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [15:0] xr, xi, wr, wi;
        logic [15:0] er, ei;
        logic        es;
        int          hold;
    } vec_t;

    initial begin
        vec_t vecs [6];
        logic [15:0] xr, xi, wr, wi, er, ei;
        logic        es;

        vecs[0] = '{"identity",   16'h2000, 16'h2000, 16'h4000, 16'h0000, 16'h2000, 16'h2000, 1'b0, -1};
        vecs[1] = '{"minus_j",    16'h2000, 16'h2000, 16'h0000, 16'hC000, 16'h2000, 16'hE000, 1'b0, 0};
        vecs[2] = '{"sequencing", 16'h1111, 16'h2222, 16'h3333, 16'h0444, 16'h0B61, 16'h1C71, 1'b0, 1};
`ifdef CMUL_SAT_EN
        vecs[3] = '{"overflow",   16'h6000, 16'hA000, 16'h4000, 16'hC000, 16'h0000, 16'h8000, 1'b1, 3};
`else
        vecs[3] = '{"overflow",   16'h6000, 16'hA000, 16'h4000, 16'hC000, 16'h0000, 16'h4000, 1'b0, 3};
`endif
        vecs[4] = '{"floor_neg",  16'hC000, 16'h0000, 16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, -1};
        vecs[5] = '{"minus2_sq",  16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 1'b0, 0};

        #1 rst = 1'b1;
        #1;
        check("reset outputs", {in_ready, out_valid, busy, out_sat, y_re, y_im, mul_a, mul_b},
              {1'b1, 1'b0, 1'b0, 1'b0, 64'h0});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i])
            run_txn(vecs[i].name, vecs[i].xr, vecs[i].xi, vecs[i].wr, vecs[i].wi,
                    vecs[i].er, vecs[i].ei, vecs[i].es, vecs[i].hold);

        for (int n = 0; n < 40; n++) begin
            xr = 16'($urandom); xi = 16'($urandom);
            wr = 16'($urandom); wi = 16'($urandom);
            if (n % 4 == 0) begin
                xr = 16'($urandom_range(32'h0000, 32'h1FFF));
                wi = 16'h4000;
            end
            ref_cmul(xr, xi, wr, wi, er, ei, es);
            run_txn($sformatf("rand%0d", n), xr, xi, wr, wi, er, ei, es,
                    int'($urandom_range(0, 3)) - 1);
        end

        // Reset during M2: outputs return to reset values and the result is never shown.
        x_re = 16'h3000; x_im = 16'h1000; w_re = 16'h2000; w_im = 16'h1000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("pre-reset in M2", {busy, mul_a, mul_b}, {1'b1, 16'h3000, 16'h1000});
        rst = 1'b1;
        #1;
        check("mid-op reset outputs",
              {in_ready, out_valid, busy, out_sat, y_re, y_im, mul_a, mul_b},
              {1'b1, 1'b0, 1'b0, 1'b0, 64'h0});
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("no stale result", {out_valid, busy, in_ready}, 3'b001);
        end
        run_txn("post_reset_identity", 16'h2000, 16'h2000, 16'h4000, 16'h0000,
                16'h2000, 16'h2000, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/twiddle_cmul_sequencer.md
# twiddle_cmul_sequencer

Time-multiplexes one shared 16-bit signed fractional multiplier to compute the complex twiddle product y = x·w for the FFT butterfly. The multiplier is external and combinational: operand A, operand B, product is bits [29:14] of the signed product. The block accepts one complex operand pair over a valid/ready handshake and issues four real multiplies on consecutive cycles. It then accumulates them and presents the complex result over a second valid/ready handshake. It sits between twiddle ROM/data fetch and the butterfly add/subtract stage.

## Interface
- No parameters; all data fixed at 16-bit two's complement, 14 fractional bits (0x4000 = +1.0, 0xC000 = −1.0).
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- x_re, x_im  input  16  data sample
- w_re, w_im  input  16  twiddle factor
- mul_a, mul_b  output  16  operands to shared multiplier
- mul_p  input  16  multiplier result (combinational from mul_a/mul_b)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- y_re, y_im  output  16  complex product
- out_sat  output  1  saturation occurred on current result
- busy  output  1  high in any state other than IDLE

## Operation
- States: IDLE, M0, M1, M2, M3, OUT.
- IDLE: in_ready=1. On in_valid & in_ready, register x_re, x_im, w_re, w_im, clear accumulators, and go to M0.
- M0: mul_a=x_re, mul_b=w_re. At end of cycle, acc_re = sext17(mul_p).
- M1: mul_a=x_im, mul_b=w_im. At end of cycle, acc_re = acc_re − sext17(mul_p).
- M2: mul_a=x_re, mul_b=w_im. At end of cycle, acc_im = sext17(mul_p).
- M3: mul_a=x_im, mul_b=w_re. At end of cycle, acc_im = acc_im + sext17(mul_p), y_re/y_im are registered from the final 17-bit sums, out_valid is set, and the FSM goes to OUT.
- OUT: hold y_re, y_im, out_sat and out_valid stable. On out_ready, clear out_valid and go to IDLE.
- Accumulators are 17-bit signed. The 16-bit conversion is per Configuration.
- mul_a and mul_b are 0 in IDLE and OUT.
- in_valid is ignored outside IDLE. Input ports are sampled only at the accepting edge.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, y_re=y_im=0, out_sat=0, mul_a=mul_b=0, internal registers 0.
- Reset asserted in any state returns to IDLE immediately. An in-flight result is discarded and never presented.
- If the accept happens at edge E: M0 runs in cycle E..E+1, and M3 in cycle E+3..E+4.
- out_valid is high from edge E+4, giving a latency of 4 cycles.
- Minimum issue interval is 6 cycles: one IDLE cycle, four multiply cycles, and at least one OUT cycle.
- out_ready may be held high in advance; OUT then lasts exactly one cycle.
- Multiplier path: mul_a/mul_b are registered by state, and mul_p must settle within the same cycle.

## Configuration
- CMUL_SAT_EN defined: each 17-bit sum outside [−32768, 32767] clamps to 0x8000 or 0x7FFF. out_sat = OR of the re/im overflow conditions.
- CMUL_SAT_EN undefined: y = low 16 bits of the sum (wrap-around), and out_sat is tied 0.
- The port list is identical in both builds.

## Test plan
- Identity: x=(0x2000,0x2000), w=(0x4000,0x0000) -> y=(0x2000,0x2000), out_sat=0. out_valid rises exactly 4 edges after accept.
- Multiply by −j: x=(0x2000,0x2000), w=(0x0000,0xC000) -> y=(0x2000,0xE000).
- Multiplier sequencing: x=(0x1111,0x2222), w=(0x3333,0x0444) -> mul_a/mul_b over M0..M3 are exactly (0x1111,0x3333), (0x2222,0x0444), (0x1111,0x0444), (0x2222,0x3333), and 0/0 otherwise.
- Overflow: x=(0x6000,0xA000), w=(0x4000,0xC000) -> y_re=0x0000.
  - With CMUL_SAT_EN: y_im=0x8000 and out_sat=1.
  - Without CMUL_SAT_EN: y_im=0x4000 and out_sat=0.
- Backpressure: hold out_ready=0 for 3 cycles in OUT -> y, out_valid and out_sat stay stable, and in_ready=0. Pulse in_valid during that time -> ignored. Raise out_ready -> one-cycle handshake, then IDLE with in_ready=1.
- Reset mid-operation: assert rst during M2 -> all outputs at their reset values immediately. After release, a new identity transaction completes correctly with no stale result.
